// File: rtl/trail_writer.sv
// trail_writer: frame-buffer write engine that clears the buffer and stamps both bikes' trail squares each frame.
// Optional border walls drawn during clear when TRAIL_BORDER_EN is defined.
module trail_writer #(
   parameter int         TRAIL_W    = 4,
   parameter logic [3:0] BG_COLOR   = 4'h8,
   parameter logic [3:0] BLUE_TRAIL = 4'h6,
   parameter logic [3:0] RED_TRAIL  = 4'h4,
   parameter logic [3:0] WALL_COLOR = 4'hE
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        clear_req,
   input  logic        paint_en,
   input  logic [9:0]  Blue_X_real,
   input  logic [9:0]  Blue_Y_real,
   input  logic [9:0]  Red_X_real,
   input  logic [9:0]  Red_Y_real,
   output logic        WE,
   output logic [18:0] write_address,
   output logic [15:0] Data_In,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, CLEAR, PAINT_B, PAINT_R} state_t;
   localparam int          HW    = TRAIL_W / 2;
   localparam logic [17:0] NW    = 18'(TRAIL_W * HW);
   localparam logic [17:0] WORDS = 18'd153600;

   state_t      state_q, state_d;
   logic [17:0] cnt_q, cnt_d;
   logic        pend_q, pend_d, boot_q, boot_d;
   logic [2:0]  sync_q, sync_d;
   logic [9:0]  bx_q, bx_d, by_q, by_d, rx_q, rx_d, ry_q, ry_d;
   logic        we_q, we_d, busy_q, busy_d, done_q, done_d;
   logic [18:0] addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic        edge_det, at_end, wall;
   logic [9:0]  px, py;
   logic [17:0] pi;
   logic [19:0] pw;
   logic [3:0]  clr_c;

   // {valid, address} of word i of a square whose top-left pixel is (x, y)
   function automatic logic [19:0] pix(input logic [9:0] x, input logic [9:0] y, input logic [17:0] i);
      logic [10:0] row;
      logic [9:0]  col;
      row = {1'b0, y} + 11'(i / 18'(HW));
      col = {1'b0, x[9:1]} + 10'(i % 18'(HW));
      return {row <= 11'd479 && col <= 10'd319, {8'd0, row} * 19'd320 + {9'd0, col}};
   endfunction

   assign edge_det = sync_q[1] & ~sync_q[2];
   assign at_end   = cnt_q == NW;
   // IDLE launches blue word 0 straight from the inputs; the last PAINT_B cycle launches red word 0
   assign px = (state_q == IDLE) ? Blue_X_real : (state_q == PAINT_B && !at_end) ? bx_q : rx_q;
   assign py = (state_q == IDLE) ? Blue_Y_real : (state_q == PAINT_B && !at_end) ? by_q : ry_q;
   assign pi = (state_q == IDLE || at_end) ? '0 : cnt_q;
   assign pw = pix(px, py, pi);

`ifdef TRAIL_BORDER_EN
   logic [8:0] col_q, col_d;
   assign wall = cnt_q < 18'd320 || cnt_q >= WORDS - 18'd320 || col_q == 9'd0 || col_q == 9'd319;
   always_comb col_d = (state_q == CLEAR && cnt_q != WORDS) ? ((col_q == 9'd319) ? 9'd0 : col_q + 9'd1) : 9'd0;
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) col_q <= '0;
      else col_q <= col_d;
`else
   assign wall = 1'b0;
`endif
   assign clr_c = wall ? WALL_COLOR : BG_COLOR;

   always_comb begin
      sync_d  = {sync_q[1:0], frame_clk};
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      boot_d  = boot_q;
      bx_d    = bx_q;
      by_d    = by_q;
      rx_d    = rx_q;
      ry_d    = ry_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear_req || pend_q || boot_q) begin
               state_d = CLEAR;
               cnt_d   = '0;
               pend_d  = 1'b0;
               boot_d  = 1'b0;
            end else if (edge_det && paint_en) begin
               bx_d           = Blue_X_real;
               by_d           = Blue_Y_real;
               rx_d           = Red_X_real;
               ry_d           = Red_Y_real;
               {we_d, addr_d} = pw;
               data_d         = {4'h0, BLUE_TRAIL, 4'h0, BLUE_TRAIL};
               cnt_d          = 18'd1;
               state_d        = PAINT_B;
            end
         end
         CLEAR: begin
            if (cnt_q == WORDS) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               we_d   = 1'b1;
               addr_d = {1'b0, cnt_q};
               data_d = {4'h0, clr_c, 4'h0, clr_c};
               cnt_d  = cnt_q + 18'd1;
            end
         end
         PAINT_B: begin
            pend_d         = pend_q | clear_req;
            {we_d, addr_d} = pw;
            data_d         = at_end ? {4'h0, RED_TRAIL, 4'h0, RED_TRAIL} : {4'h0, BLUE_TRAIL, 4'h0, BLUE_TRAIL};
            cnt_d          = at_end ? 18'd1 : cnt_q + 18'd1;
            state_d        = at_end ? PAINT_R : PAINT_B;
         end
         default: begin
            pend_d = pend_q | clear_req;
            if (!at_end) begin
               {we_d, addr_d} = pw;
               data_d         = {4'h0, RED_TRAIL, 4'h0, RED_TRAIL};
               cnt_d          = cnt_q + 18'd1;
            end else if (pend_d) begin
               state_d = CLEAR;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         boot_q  <= 1'b1;
         sync_q  <= '0;
         bx_q    <= '0;
         by_q    <= '0;
         rx_q    <= '0;
         ry_q    <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         boot_q  <= boot_d;
         sync_q  <= sync_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         rx_q    <= rx_d;
         ry_q    <= ry_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign WE            = we_q;
   assign write_address = addr_q;
   assign Data_In       = data_q;
   assign busy          = busy_q;
   assign done          = done_q;
endmodule
